// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction prefetch queue between synchronous program memory
// (1-cycle read latency) and the fetch/decode controller.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   mem_en       read strobe to program memory (combinational credit decision)
//   mem_addr     read word address, valid while mem_en=1
//   mem_data     read data, valid the cycle after mem_en=1
//   redir_valid  one-cycle redirect: flush queue and in-flight read, restart at redir_addr
//   redir_addr   redirect target word address
//   stop         suppress new reads; queued words keep draining
//   out_valid    FIFO head valid
//   out_data     head instruction word
//   out_pc       word address of out_data
//   out_ready    consumer accepts the head this cycle
module instr_prefetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_addr,
  input  logic          stop,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // One queue entry: instruction word tagged with its word address.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [AW-1:0]   inflight_pc;
  logic [AW-1:0]   fetch_addr;

  logic [CW:0]     used;
  logic            issue;
  logic            push;
  logic            pop;

  // Credits include the outstanding read, so a landing response always has a slot.
  // out_ready is deliberately absent here: no combinational ready->memory path.
  always_comb begin
    used  = {1'b0, count} + (CW+1)'(inflight);
    issue = !reset && !stop && !redir_valid && (used < (CW+1)'(DEPTH));
  end

  assign mem_en   = issue;
  assign mem_addr = fetch_addr;

  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign push = inflight && !redir_valid;

  assign out_valid = !reset && (count != '0);
  assign out_data  = fifo_q[rd_ptr].data;
  assign out_pc    = fifo_q[rd_ptr].pc;
  assign pop       = out_valid && out_ready;

  // Control state: fetch pointer, in-flight tracking, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr  <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redir_valid) begin
      fetch_addr <= redir_addr;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_addr  <= fetch_addr + AW'(1);
        inflight_pc <= fetch_addr;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_q[wr_ptr] <= '{data: mem_data, pc: inflight_pc};
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic        redir_valid;
  logic [15:0] redir_addr;
  logic        stop;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_pc;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  instr_prefetch #(.DEPTH(4), .AW(16), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .redir_valid(redir_valid), .redir_addr(redir_addr), .stop(stop),
    .out_valid(out_valid), .out_data(out_data), .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Program memory: 1-cycle read latency, garbage when not read.
  always @(posedge clk) mem_data <= mem_en ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] ra;
    logic        st;
    logic        rdy;
    logic        e_en;
    logic [15:0] e_addr;
    logic        e_ov;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic rv, input logic [15:0] ra,
                              input logic st, input logic rdy, input logic e_en,
                              input logic [15:0] e_addr, input logic e_ov,
                              input logic [15:0] e_pc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.ra = ra; v.st = st; v.rdy = rdy;
    v.e_en = e_en; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance past the next edge.
  task automatic step(input vec_t v, input string tag, input int idx);
    reset = v.rst; redir_valid = v.rv; redir_addr = v.ra; stop = v.st; out_ready = v.rdy;
    @(negedge clk);
    chk($sformatf("%s[%0d] mem_en", tag, idx), 32'(mem_en), 32'(v.e_en));
    if (v.e_en) chk($sformatf("%s[%0d] mem_addr", tag, idx), 32'(mem_addr), 32'(v.e_addr));
    chk($sformatf("%s[%0d] out_valid", tag, idx), 32'(out_valid), 32'(v.e_ov));
    if (v.e_ov) begin
      chk($sformatf("%s[%0d] out_pc", tag, idx), 32'(out_pc), 32'(v.e_pc));
      chk($sformatf("%s[%0d] out_data", tag, idx), out_data, mem_word(v.e_pc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    reset = 1'b1; redir_valid = 1'b0; redir_addr = '0; stop = 1'b0; out_ready = 1'b0;

    // Reset, then streaming with out_ready=1.
    add(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    add(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int c = 0; c < 8; c++) add(mk(0, 0, 0, 0, 1, 1, 16'(c), c >= 2, 16'(c - 2)));
    // Redirect to 0xFFFE mid-stream: head pc 6 consumed, address wraps.
    add(mk(0, 1, 16'hFFFE, 0, 1, 0, 0, 1, 16'd6));
    add(mk(0, 0, 0, 0, 1, 1, 16'hFFFE, 0, 0));
    add(mk(0, 0, 0, 0, 1, 1, 16'hFFFF, 0, 0));
    add(mk(0, 0, 0, 0, 1, 1, 16'h0000, 1, 16'hFFFE));
    add(mk(0, 0, 0, 0, 1, 1, 16'h0001, 1, 16'hFFFF));
    add(mk(0, 0, 0, 0, 1, 1, 16'h0002, 1, 16'h0000));
    add(mk(0, 0, 0, 0, 1, 1, 16'h0003, 1, 16'h0001));
    // stop for 5 cycles: in-flight word 3 still delivered, resume at 4.
    add(mk(0, 0, 0, 1, 1, 0, 0, 1, 16'd2));
    add(mk(0, 0, 0, 1, 1, 0, 0, 1, 16'd3));
    add(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(mk(0, 0, 0, 0, 1, 1, 16'd4, 0, 0));
    add(mk(0, 0, 0, 0, 1, 1, 16'd5, 0, 0));
    add(mk(0, 0, 0, 0, 1, 1, 16'd6, 1, 16'd4));
    add(mk(0, 0, 0, 0, 1, 1, 16'd7, 1, 16'd5));
    // Fill with out_ready=0, then reset with 3 queued + 1 in flight.
    add(mk(0, 0, 0, 0, 0, 1, 16'd8, 1, 16'd6));
    add(mk(0, 0, 0, 0, 0, 1, 16'd9, 1, 16'd6));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 4; c++) add(mk(0, 0, 0, 0, 1, 1, 16'(c), c >= 2, 16'(c - 2)));
    // Backpressure from start: 4 words queued, then drain 0..7 in order.
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 7; c++) add(mk(0, 0, 0, 0, 0, c < 4, 16'(c), c >= 2, 16'd0));
    add(mk(0, 0, 0, 0, 1, 0, 0, 1, 16'd0));
    for (int c = 8; c < 15; c++) add(mk(0, 0, 0, 0, 1, 1, 16'(c - 4), 1, 16'(c - 7)));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], "vec", i);

    // Redirect while 3 queued + 1 in flight, out_ready=1 in the same cycle.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "redir", 0);
    for (int c = 0; c < 4; c++) step(mk(0, 0, 0, 0, 0, 1, 16'(c), c >= 2, 16'd0), "redir", c + 1);
    step(mk(0, 1, 16'h0100, 0, 1, 0, 0, 1, 16'd0), "redir", 5);
    step(mk(0, 0, 0, 0, 1, 1, 16'h0100, 0, 0), "redir", 6);
    step(mk(0, 0, 0, 0, 1, 1, 16'h0101, 0, 0), "redir", 7);
    step(mk(0, 0, 0, 0, 1, 1, 16'h0102, 1, 16'h0100), "redir", 8);
    step(mk(0, 0, 0, 0, 1, 1, 16'h0103, 1, 16'h0101), "redir", 9);

    // Redirect with stop held: flush and load happen, read waits for stop to drop.
    step(mk(0, 1, 16'h0200, 1, 1, 0, 0, 1, 16'h0102), "rstop", 0);
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0), "rstop", 1);
    step(mk(0, 0, 0, 0, 1, 1, 16'h0200, 0, 0), "rstop", 2);
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid || waited >= 8) break;
      waited++;
      @(posedge clk);
      #1;
    end
    chk("rstop first_valid_wait", 32'(waited), 32'd1);
    chk("rstop first_pc", 32'(out_pc), 32'h0200);
    chk("rstop first_data", out_data, mem_word(16'h0200));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
